// File: rtl/cla_div_pkg.sv
// Shared types and helpers for the iterative CLA-based divider.
package cla_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    localparam int SLICE_W = 4;

    // Number of 4-bit CLA slices needed to cover a w-bit datapath.
    function automatic int n_slices(int w);
        return (w + SLICE_W - 1) / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_4_bit.sv
// 4-bit carry-lookahead adder slice: sum = a + b + cin, with lookahead carry-out.
module cla_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and fully expanded lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_sub_n.sv
// W-bit unsigned subtractor a - b built as a + ~b + 1 over a chain of cla_4_bit
// slices. The datapath is zero-padded up to a whole number of slices; since the
// padded bits of b invert to ones, the final carry-out still means a >= b.
module cla_sub_n
    import cla_div_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    localparam int NS = n_slices(W);
    localparam int PW = NS * SLICE_W;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_inv;
    logic [PW-1:0] sum;
    logic [NS:0]   carry;

    assign a_ext    = PW'(a);
    assign b_inv    = ~(PW'(b));
    assign carry[0] = 1'b1;

    // Ripple the lookahead carry from slice to slice.
    cla_4_bit u_slice [NS-1:0] (
        .a    (a_ext),
        .b    (b_inv),
        .cin  (carry[NS-1:0]),
        .sum  (sum),
        .cout (carry[NS:1])
    );

    assign diff      = sum[W-1:0];
    assign no_borrow = carry[NS];

    generate
        if (PW > W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^sum[PW-1:W];
        end
    endgenerate

endmodule

// File: rtl/cla_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Trial subtraction uses a (WIDTH+1)-bit cla_sub_n so a shifted remainder that
// reaches 2^WIDTH never shows up as a false borrow.
// Optional feature: `CLA_DIV_FAST_PATH_EN finishes divide-by-zero and
// dividend<divisor in a single cycle.
module cla_seq_divider
    import cla_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $fatal(1, "cla_seq_divider: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    div_state_t      state;
    logic [WIDTH:0]   rem_q;     // partial remainder R
    logic [WIDTH-1:0] quo_q;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;
    logic             dbz_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             unused_rem_msb;

    // R always stays below the divisor, so its top bit is zero between
    // iterations; the bit that matters is the one shifted in from R[WIDTH-1].
    assign rem_shift      = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign unused_rem_msb = rem_q[WIDTH];

    cla_sub_n #(.W(WIDTH + 1)) u_sub (
        .a         (rem_shift),
        .b         ({1'b0, dvs_q}),
        .diff      (trial),
        .no_borrow (no_borrow)
    );

    // Accept, iterate and hand off; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            count <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (in_valid) begin
                        dvs_q <= divisor;
                        dbz_q <= (divisor == '0);
                        rem_q <= '0;
                        quo_q <= dividend;
                        count <= CW'(WIDTH - 1);
                        state <= DIV_CALC;
`ifdef CLA_DIV_FAST_PATH_EN
                        if (divisor == '0) begin
                            quo_q <= '1;
                            rem_q <= {1'b0, dividend};
                            state <= DIV_DONE;
                        end else if (dividend < divisor) begin
                            quo_q <= '0;
                            rem_q <= {1'b0, dividend};
                            state <= DIV_DONE;
                        end
`endif
                    end
                end
                DIV_CALC: begin
                    rem_q <= no_borrow ? trial : rem_shift;
                    quo_q <= {quo_q[WIDTH-2:0], no_borrow};
                    if (count == '0) begin
                        state <= DIV_DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign in_ready    = (state == DIV_IDLE);
    assign out_valid   = (state == DIV_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule
